scalar_mult_ctrl: RTL and testbench



---
 rtl/scalar_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_scalar_mult_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_ctrl.sv
// Left-to-right double-and-add sequencer for SM9 scalar multiplication.
// Drives point_double / point_add through their en/sign handshake and holds accumulator Q.
module scalar_mult_ctrl #(
   parameter int KW    = 256,
   parameter int DW    = 256,
   parameter int GUARD = 3
) (
   input  logic          clk,
   input  logic          rst_b,
   input  logic          start,
   input  logic [KW-1:0] k,
   input  logic [DW-1:0] px,
   input  logic [DW-1:0] py,
   output logic          busy,
   output logic          done,
   output logic [DW-1:0] qx,
   output logic [DW-1:0] qy,
   output logic          q_inf,
   output logic          dbl_en,
   output logic [DW-1:0] dbl_x,
   output logic [DW-1:0] dbl_y,
   input  logic [DW-1:0] dbl_xo,
   input  logic [DW-1:0] dbl_yo,
   input  logic          dbl_sign,
   output logic          add_en,
   output logic [DW-1:0] add_x0,
   output logic [DW-1:0] add_y0,
   output logic [DW-1:0] add_x1,
   output logic [DW-1:0] add_y1,
   input  logic [DW-1:0] add_xo,
   input  logic [DW-1:0] add_yo,
   input  logic          add_sign
);

   localparam int CW = (KW > 1) ? $clog2(KW) : 1;
   localparam int GW = (GUARD > 0) ? $clog2(GUARD + 1) : 1;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_SCAN = 3'd1,
      S_NEXT = 3'd2,
      S_DBL  = 3'd3,
      S_ADD  = 3'd4,
      S_FIN  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [KW-1:0] kr_q, kr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] g_q, g_d;
   logic [DW-1:0] pxr_q, pxr_d, pyr_q, pyr_d;
   logic [DW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
   logic          busy_q, busy_d, done_q, done_d, q_inf_q, q_inf_d;
   logic [DW-1:0] qx_q, qx_d, qy_q, qy_d;
   logic          dbl_en_q, dbl_en_d, add_en_q, add_en_d;
   logic [DW-1:0] dbl_x_q, dbl_x_d, dbl_y_q, dbl_y_d;
   logic [DW-1:0] add_x0_q, add_x0_d, add_y0_q, add_y0_d;
   logic [DW-1:0] add_x1_q, add_x1_d, add_y1_q, add_y1_d;

   // State and datapath registers; reset also drops both unit enables at once.
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state_q  <= S_IDLE;
         kr_q     <= {KW{1'b0}};
         cnt_q    <= {CW{1'b0}};
         g_q      <= {GW{1'b0}};
         pxr_q    <= {DW{1'b0}};
         pyr_q    <= {DW{1'b0}};
         acc_x_q  <= {DW{1'b0}};
         acc_y_q  <= {DW{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         q_inf_q  <= 1'b0;
         qx_q     <= {DW{1'b0}};
         qy_q     <= {DW{1'b0}};
         dbl_en_q <= 1'b0;
         add_en_q <= 1'b0;
         dbl_x_q  <= {DW{1'b0}};
         dbl_y_q  <= {DW{1'b0}};
         add_x0_q <= {DW{1'b0}};
         add_y0_q <= {DW{1'b0}};
         add_x1_q <= {DW{1'b0}};
         add_y1_q <= {DW{1'b0}};
      end else begin
         state_q  <= state_d;
         kr_q     <= kr_d;
         cnt_q    <= cnt_d;
         g_q      <= g_d;
         pxr_q    <= pxr_d;
         pyr_q    <= pyr_d;
         acc_x_q  <= acc_x_d;
         acc_y_q  <= acc_y_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         q_inf_q  <= q_inf_d;
         qx_q     <= qx_d;
         qy_q     <= qy_d;
         dbl_en_q <= dbl_en_d;
         add_en_q <= add_en_d;
         dbl_x_q  <= dbl_x_d;
         dbl_y_q  <= dbl_y_d;
         add_x0_q <= add_x0_d;
         add_y0_q <= add_y0_d;
         add_x1_q <= add_x1_d;
         add_y1_q <= add_y1_d;
      end
   end

   // Next-state and output logic for the double-and-add sequence.
   always_comb begin
      state_d  = state_q;
      kr_d     = kr_q;
      cnt_d    = cnt_q;
      g_d      = g_q;
      pxr_d    = pxr_q;
      pyr_d    = pyr_q;
      acc_x_d  = acc_x_q;
      acc_y_d  = acc_y_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      q_inf_d  = q_inf_q;
      qx_d     = qx_q;
      qy_d     = qy_q;
      dbl_en_d = dbl_en_q;
      add_en_d = add_en_q;
      dbl_x_d  = dbl_x_q;
      dbl_y_d  = dbl_y_q;
      add_x0_d = add_x0_q;
      add_y0_d = add_y0_q;
      add_x1_d = add_x1_q;
      add_y1_d = add_y1_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               kr_d    = k;
               pxr_d   = px;
               pyr_d   = py;
               cnt_d   = CW'(KW - 1);
               busy_d  = 1'b1;
               state_d = S_SCAN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (kr_q[KW-1]) begin
               acc_x_d = pxr_q;
               acc_y_d = pyr_q;
               state_d = S_NEXT;
            end else if (cnt_q == {CW{1'b0}}) begin
               q_inf_d = 1'b1;
               qx_d    = {DW{1'b0}};
               qy_d    = {DW{1'b0}};
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               kr_d  = kr_q << 1;
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_NEXT: begin
            if (cnt_q == {CW{1'b0}}) begin
               qx_d    = acc_x_q;
               qy_d    = acc_y_q;
               q_inf_d = 1'b0;
               done_d  = 1'b1;
               state_d = S_FIN;
            end else begin
               kr_d     = kr_q << 1;
               cnt_d    = cnt_q - CW'(1);
               dbl_x_d  = acc_x_q;
               dbl_y_d  = acc_y_q;
               dbl_en_d = 1'b1;
               g_d      = {GW{1'b0}};
               state_d  = S_DBL;
            end
         end
         // The unit may still show the previous op's sign for a few cycles after en rises.
         S_DBL: begin
            if (g_q != GW'(GUARD)) begin
               g_d = g_q + GW'(1);
            end else if (dbl_sign) begin
               acc_x_d  = dbl_xo;
               acc_y_d  = dbl_yo;
               dbl_en_d = 1'b0;
               if (kr_q[KW-1]) begin
                  add_x0_d = dbl_xo;
                  add_y0_d = dbl_yo;
                  add_x1_d = pxr_q;
                  add_y1_d = pyr_q;
                  add_en_d = 1'b1;
                  g_d      = {GW{1'b0}};
                  state_d  = S_ADD;
               end else begin
                  state_d = S_NEXT;
               end
            end else begin
               g_d = g_q;
            end
         end
         S_ADD: begin
            if (g_q != GW'(GUARD)) begin
               g_d = g_q + GW'(1);
            end else if (add_sign) begin
               acc_x_d  = add_xo;
               acc_y_d  = add_yo;
               add_en_d = 1'b0;
               state_d  = S_NEXT;
            end else begin
               g_d = g_q;
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            dbl_en_d = 1'b0;
            add_en_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
         end
      endcase
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign qx     = qx_q;
   assign qy     = qy_q;
   assign q_inf  = q_inf_q;
   assign dbl_en = dbl_en_q;
   assign dbl_x  = dbl_x_q;
   assign dbl_y  = dbl_y_q;
   assign add_en = add_en_q;
   assign add_x0 = add_x0_q;
   assign add_y0 = add_y0_q;
   assign add_x1 = add_x1_q;
   assign add_y1 = add_y1_q;

endmodule

// File: tb/tb_scalar_mult_ctrl.sv
// Directed bench for scalar_mult_ctrl with behavioural point_double / point_add stubs.
module tb_scalar_mult_ctrl;

   localparam int KW = 256;
   localparam int DW = 256;
   localparam int SIGN_LAT = 20;

   localparam logic [DW-1:0] SM_PX = 256'h93DE051D62BF718FF5ED0704487D01D6E1E4086909DC3280E8C4E4817C66DDDD;
   localparam logic [DW-1:0] SM_PY = 256'h21FE8DDA4F21E607631065125C395BBC1C1C00CBFA6024350C464CD70A3EA616;
   localparam logic [DW-1:0] PX2   = 256'h1000;
   localparam logic [DW-1:0] PY2   = 256'h2222;

   logic          clk = 1'b0;
   logic          rst_b, start;
   logic [KW-1:0] k;
   logic [DW-1:0] px, py;
   logic          busy, done, q_inf;
   logic [DW-1:0] qx, qy;
   logic          dbl_en, dbl_sign, add_en, add_sign;
   logic [DW-1:0] dbl_x, dbl_y, dbl_xo, dbl_yo;
   logic [DW-1:0] add_x0, add_y0, add_x1, add_y1, add_xo, add_yo;

   int total = 0;
   int bad   = 0;

   logic          stale_mode = 1'b0;
   int            dcnt = 0;
   int            acnt = 0;
   logic [1:0]    ops[$];
   logic          dbl_en_p = 1'b0, add_en_p = 1'b0;
   logic          overlap = 1'b0;
   logic [DW-1:0] last_add_x1 = '0;

   always #5 clk = ~clk;

   scalar_mult_ctrl #(.KW(KW), .DW(DW), .GUARD(3)) dut (
      .clk(clk), .rst_b(rst_b), .start(start), .k(k), .px(px), .py(py),
      .busy(busy), .done(done), .qx(qx), .qy(qy), .q_inf(q_inf),
      .dbl_en(dbl_en), .dbl_x(dbl_x), .dbl_y(dbl_y),
      .dbl_xo(dbl_xo), .dbl_yo(dbl_yo), .dbl_sign(dbl_sign),
      .add_en(add_en), .add_x0(add_x0), .add_y0(add_y0), .add_x1(add_x1), .add_y1(add_y1),
      .add_xo(add_xo), .add_yo(add_yo), .add_sign(add_sign)
   );

   // Stub units: result x+1 / x0+0x100 valid only after SIGN_LAT cycles of en.
   always @(posedge clk) begin
      dcnt <= dbl_en ? ((dcnt < 1000) ? dcnt + 1 : dcnt) : 0;
      acnt <= add_en ? ((acnt < 1000) ? acnt + 1 : acnt) : 0;
   end

   assign dbl_sign = stale_mode ? (dbl_en ? (dcnt < 2 || dcnt >= SIGN_LAT) : 1'b1)
                                : (dbl_en && dcnt >= SIGN_LAT);
   assign add_sign = stale_mode ? (add_en ? (acnt < 2 || acnt >= SIGN_LAT) : 1'b1)
                                : (add_en && acnt >= SIGN_LAT);
   assign dbl_xo = (dcnt >= SIGN_LAT) ? dbl_x + 256'd1 : '0;
   assign dbl_yo = dbl_y;
   assign add_xo = (acnt >= SIGN_LAT) ? add_x0 + 256'h100 : '0;
   assign add_yo = add_y0;

   // Operation-sequence monitor: 1 = double, 2 = add.
   always @(posedge clk) begin
      dbl_en_p <= dbl_en;
      add_en_p <= add_en;
      if (dbl_en && add_en) overlap <= 1'b1;
      if (dbl_en && !dbl_en_p) ops.push_back(2'd1);
      if (add_en && !add_en_p) begin
         ops.push_back(2'd2);
         last_add_x1 <= add_x1;
      end
   end

   task automatic chk_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] seq_code();
      logic [31:0] c = 32'd0;
      foreach (ops[i]) c = (c << 2) | {30'd0, ops[i]};
      return c;
   endfunction

   task automatic pulse_start(input logic [KW-1:0] kv, input logic [DW-1:0] x, input logic [DW-1:0] y);
      k = kv; px = x; py = y; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget, output int cyc);
      cyc = 0;
      while (!done && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic check_after_done(input string tag);
      @(posedge clk); #1;
      chk_eq({tag, "_done_1cyc"}, {255'd0, done}, 256'd0);
      chk_eq({tag, "_busy_low"}, {255'd0, busy}, 256'd0);
   endtask

   initial begin
      int cyc;
      rst_b = 1'b1; start = 1'b0; k = '0; px = '0; py = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_busy", {255'd0, busy}, 256'd0);
      chk_eq("rst_done", {255'd0, done}, 256'd0);
      chk_eq("rst_dbl_en", {255'd0, dbl_en}, 256'd0);
      chk_eq("rst_add_en", {255'd0, add_en}, 256'd0);
      chk_eq("rst_qx", qx, 256'd0);
      rst_b = 1'b0;
      @(posedge clk); #1;

      // k=1: result is P, no unit operations; 255 shifts + MSB hit + NEXT.
      ops.delete();
      pulse_start(256'd1, SM_PX, SM_PY);
      chk_eq("k1_busy", {255'd0, busy}, 256'd1);
      wait_done(5000, cyc);
      chk_eq("k1_done", {255'd0, done}, 256'd1);
      chk_eq("k1_lat", 256'(cyc), 256'd257);
      chk_eq("k1_qx", qx, SM_PX);
      chk_eq("k1_qy", qy, SM_PY);
      chk_eq("k1_qinf", {255'd0, q_inf}, 256'd0);
      chk_eq("k1_ops", 256'(ops.size()), 256'd0);
      check_after_done("k1");

      // k=0: 256 SCAN steps then point at infinity.
      ops.delete();
      pulse_start(256'd0, SM_PX, SM_PY);
      wait_done(5000, cyc);
      chk_eq("k0_done", {255'd0, done}, 256'd1);
      chk_eq("k0_lat", 256'(cyc), 256'd256);
      chk_eq("k0_qinf", {255'd0, q_inf}, 256'd1);
      chk_eq("k0_qx", qx, 256'd0);
      chk_eq("k0_qy", qy, 256'd0);
      chk_eq("k0_ops", 256'(ops.size()), 256'd0);
      check_after_done("k0");

      // k=0xB with a second start (k=5) while busy: D,D,A,D,A -> x+0x203.
      ops.delete();
      pulse_start(256'hB, PX2, PY2);
      repeat (30) @(posedge clk);
      #1;
      pulse_start(256'h5, 256'h7777, 256'h8888);
      wait_done(5000, cyc);
      chk_eq("kB_done", {255'd0, done}, 256'd1);
      chk_eq("kB_qx", qx, 256'h1203);
      chk_eq("kB_qy", qy, PY2);
      chk_eq("kB_qinf", {255'd0, q_inf}, 256'd0);
      chk_eq("kB_seq", {224'd0, seq_code()}, 256'h166);
      chk_eq("kB_addP", last_add_x1, PX2);
      check_after_done("kB");

      // New start after done is accepted: k=5 -> D,D,A -> x+0x102.
      ops.delete();
      pulse_start(256'h5, PX2, PY2);
      wait_done(5000, cyc);
      chk_eq("k5_done", {255'd0, done}, 256'd1);
      chk_eq("k5_qx", qx, 256'h1102);
      chk_eq("k5_seq", {224'd0, seq_code()}, 256'h16);
      check_after_done("k5");

      // Stale sign right after en rises and sign high while en is low.
      stale_mode = 1'b1;
      ops.delete();
      pulse_start(256'hB, PX2, PY2);
      wait_done(5000, cyc);
      chk_eq("stale_done", {255'd0, done}, 256'd1);
      chk_eq("stale_qx", qx, 256'h1203);
      chk_eq("stale_seq", {224'd0, seq_code()}, 256'h166);
      check_after_done("stale");
      stale_mode = 1'b0;

      // Reset during the second doubling of k=0xB.
      ops.delete();
      pulse_start(256'hB, PX2, PY2);
      cyc = 0;
      while (ops.size() < 2 && cyc < 5000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk_eq("rst2_reached", 256'(ops.size()), 256'd2);
      repeat (4) @(posedge clk);
      #1;
      rst_b = 1'b1;
      #1;
      chk_eq("rst2_dbl_en", {255'd0, dbl_en}, 256'd0);
      chk_eq("rst2_add_en", {255'd0, add_en}, 256'd0);
      chk_eq("rst2_busy", {255'd0, busy}, 256'd0);
      chk_eq("rst2_done", {255'd0, done}, 256'd0);
      chk_eq("rst2_qx", qx, 256'd0);
      chk_eq("rst2_dbl_x", dbl_x, 256'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk_eq("rst2_no_done", {255'd0, done}, 256'd0);
      end
      rst_b = 1'b0;
      @(posedge clk); #1;
      chk_eq("rst2_idle_done", {255'd0, done}, 256'd0);

      // Fresh k=2 after reset: one doubling -> x+1.
      ops.delete();
      pulse_start(256'h2, PX2, PY2);
      wait_done(5000, cyc);
      chk_eq("k2_done", {255'd0, done}, 256'd1);
      chk_eq("k2_qx", qx, 256'h1001);
      chk_eq("k2_qy", qy, PY2);
      chk_eq("k2_seq", {224'd0, seq_code()}, 256'h1);
      check_after_done("k2");

      chk_eq("no_overlap", {255'd0, overlap}, 256'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
